imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the CPU's instruction fetch.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them sequentially into a 16-entry instruction memory.
- Serves registered instruction reads to the CPU fetch port.
- Holds the CPU in reset until a load completes.

Parameters:
- WORD_W, 16, instruction word width (fixed at 2 bytes)
- DEPTH, 16, number of instruction words
- ADDR_W, 4, address width, equal to log2(DEPTH)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new load
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_last  in  1  qualifies the final byte of the program
- byte_ready  out  1  loader accepts a byte this cycle
- fetch_addr  in  ADDR_W  CPU program counter
- fetch_instr  out  WORD_W  registered instruction at fetch_addr
- loading  out  1  load in progress
- done  out  1  load completed; memory valid
- cpu_hold  out  1  CPU reset request
- word_count  out  ADDR_W+1  words written in the current/last load (0..16)
- err  out  1  sticky; load ended on an odd byte count

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - byte_ready=0, fetch_instr=0x0000, loading=0, done=0, cpu_hold=1, word_count=0, err=0.
  - All per-entry valid bits are cleared. Memory contents need not be cleared.
- States: IDLE, LOAD_HI, LOAD_LO, WRITE, DONE.
  - A byte transfers only when byte_valid && byte_ready.
- IDLE:
  - byte_ready=0, cpu_hold=1.
  - start -> LOAD_HI. On entry, the write address, word_count, err and all valid bits are cleared.
- LOAD_HI:
  - byte_ready=1, loading=1.
  - On transfer: hi <= byte_data.
  - If byte_last: lo <= 0x00, err <= 1, go to WRITE with the finish flag set.
  - Otherwise go to LOAD_LO.
- LOAD_LO:
  - byte_ready=1.
  - On transfer: lo <= byte_data, finish flag <= byte_last, go to WRITE.
- WRITE:
  - byte_ready=0 (one bubble per word).
  - mem[addr] <= {hi, lo}, valid[addr] <= 1, word_count += 1.
  - If finish, or addr == DEPTH-1: go to DONE. Otherwise addr += 1 and go to LOAD_HI.
  - Address never wraps. The 16th word always ends the load, even without byte_last; further stream bytes see byte_ready=0.
- DONE:
  - done=1, loading=0, cpu_hold=0, byte_ready=0.
  - start -> LOAD_HI (reload): done deasserts and cpu_hold reasserts in the next cycle.
- start outside IDLE/DONE is ignored.
- cpu_hold is a registered output:
  - 1 in every state except DONE.
  - Drops on the cycle after DONE is entered.
- Fetch port:
  - fetch_instr <= (done && valid[fetch_addr]) ? mem[fetch_addr] : 0x0000. Latency is 1 cycle.
  - Unloaded entries and all reads while not in DONE return 0x0000 (NOP).
- Throughput: one word per 3 cycles with byte_valid held high.
- Reset mid-load:
  - Returns to IDLE with all valid bits cleared; partial data is unreachable.
  - byte_ready drops asynchronously.

Test Plan:
- Reset, then start; stream 0x12,0x34,0xAB,0xCD with last on 0xCD -> word_count=2, done=1, err=0, cpu_hold=0 one cycle after done. fetch_addr=0 gives fetch_instr=0x1234 next cycle; addr 1 gives 0xABCD; addr 2 gives 0x0000.
- Stream 34 bytes without byte_last -> exactly 32 accepted, DONE after the 16th word, byte_ready=0 for bytes 33-34, word_count=16, fetch_addr=15 returns the last word.
- Stream 0x7E,0x55,0x99 with last on 0x99 -> word_count=2, err=1, mem[1]=0x9900.
- Toggle byte_valid every other cycle -> same memory image as a continuous stream; byte_ready never high in WRITE.
- Assert reset after 3 words; then start and load 1 word 0xBEEF -> addr 0 reads 0xBEEF, addrs 1-3 read 0x0000, err=0.
- In DONE, pulse start -> done=0 and cpu_hold=1 next cycle, fetch_instr=0x0000 during the reload, and old entries read 0x0000 until rewritten.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream load port, CPU fetch port and load status of the instruction memory loader.
interface imem_loader_if #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 16
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic [WORD_W-1:0] fetch_instr;
    logic              loading;
    logic              done;
    logic              cpu_hold;
    logic [ADDR_W:0]   word_count;
    logic              err;

    modport master (
        output start, byte_valid, byte_data, byte_last, fetch_addr,
        input  byte_ready, fetch_instr, loading, done, cpu_hold, word_count, err
    );

    modport slave (
        input  start, byte_valid, byte_data, byte_last, fetch_addr,
        output byte_ready, fetch_instr, loading, done, cpu_hold, word_count, err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 16-bit words, writes them into a
// small instruction memory and serves registered CPU fetches once the load is done.
module imem_loader #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic         clk,
    input logic         reset,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        hi, lo;
    logic              fin;
    logic [DEPTH-1:0]  valid;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] fetch_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q, hold_q;
    logic              xfer, restart, last_slot;

    assign bus.byte_ready  = state == LOAD_HI || state == LOAD_LO;
    assign bus.loading     = state == LOAD_HI || state == LOAD_LO || state == WRITE;
    assign bus.done        = state == DONE;
    assign bus.fetch_instr = fetch_q;
    assign bus.word_count  = count_q;
    assign bus.err         = err_q;
    assign bus.cpu_hold    = hold_q;

    assign xfer      = bus.byte_valid && bus.byte_ready;
    assign restart   = bus.start && (state == IDLE || state == DONE);
    assign last_slot = addr == ADDR_W'(DEPTH - 1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = bus.start ? LOAD_HI : state;
            LOAD_HI:    state_nxt = !bus.byte_valid ? LOAD_HI : bus.byte_last ? WRITE : LOAD_LO;
            LOAD_LO:    state_nxt = bus.byte_valid ? WRITE : LOAD_LO;
            WRITE:      state_nxt = (fin || last_slot) ? DONE : LOAD_HI;
            default:    state_nxt = IDLE;
        endcase
    end

    // hold is released only while DONE persists, so it drops one cycle after DONE
    // is entered and is back up on the same edge that a reload leaves DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr    <= '0;
            hi      <= '0;
            lo      <= '0;
            fin     <= 1'b0;
            valid   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            fetch_q <= '0;
        end else begin
            state   <= state_nxt;
            hold_q  <= !(state == DONE && state_nxt == DONE);
            fetch_q <= (state == DONE && valid[bus.fetch_addr]) ? mem[bus.fetch_addr] : '0;
            if (restart) begin
                addr    <= '0;
                count_q <= '0;
                err_q   <= 1'b0;
                valid   <= '0;
                fin     <= 1'b0;
            end
            if (xfer && state == LOAD_HI) begin
                hi <= bus.byte_data;
                if (bus.byte_last) begin
                    lo    <= 8'h00;
                    err_q <= 1'b1;
                    fin   <= 1'b1;
                end
            end
            if (xfer && state == LOAD_LO) begin
                lo  <= bus.byte_data;
                fin <= bus.byte_last;
            end
            if (state == WRITE) begin
                valid[addr] <= 1'b1;
                count_q     <= count_q + 1'b1;
                if (!(fin || last_slot))
                    addr <= addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk)
        if (state == WRITE)
            mem[addr] <= {hi, lo};
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: loads several byte streams and checks status, handshake timing and
// fetched words against a bench-side model and constant vector table.
module tb_imem_loader;
    typedef struct {
        logic [3:0]  addr;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(4), .WORD_W(16)) bus();
    imem_loader #(.WORD_W(16), .DEPTH(16), .ADDR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    int          checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mm[16];
    bit          mv[16];
    int          ma, mcount, accepted;
    bit          merr;
    logic [7:0]  mh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        ma = 0;
        mcount = 0;
        merr = 0;
        accepted = 0;
        foreach (mv[k]) mv[k] = 0;
    endtask

    task automatic start_load();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        model_clear();
        check("loading_after_start", bus.loading, 1);
        check("done_after_start", bus.done, 0);
        check("hold_after_start", bus.cpu_hold, 1);
        check("count_after_start", bus.word_count, 0);
    endtask

    // drives bytes, tracking transfers in the model; a completed word implies a WRITE bubble next
    task automatic stream(input logic [7:0] b[$], input int last_idx, input bit toggle);
        int i = 0;
        bit hi_ph = 1, ph = 1, wr = 0;
        logic rdy;
        for (int cyc = 0; cyc < 400 && i < b.size() && !bus.done; cyc++) begin
            if (wr) begin
                check("ready_in_write", bus.byte_ready, 0);
                wr = 0;
            end
            bus.byte_valid = toggle ? ph : 1'b1;
            ph = !ph;
            bus.byte_data = b[i];
            bus.byte_last = (i == last_idx);
            rdy = bus.byte_ready;
            @(negedge clk);
            if (bus.byte_valid && rdy) begin
                accepted++;
                if (hi_ph) begin
                    mh = b[i];
                    if (i == last_idx) begin
                        if (ma < 16) begin mm[ma] = {b[i], 8'h00}; mv[ma] = 1; end
                        mcount++;
                        merr = 1;
                        wr = 1;
                    end else hi_ph = 0;
                end else begin
                    if (ma < 16) begin mm[ma] = {mh, b[i]}; mv[ma] = 1; end
                    mcount++;
                    ma++;
                    hi_ph = 1;
                    wr = 1;
                end
                i++;
            end
        end
        bus.byte_valid = 1'b0;
        bus.byte_last = 1'b0;
        if (wr) check("ready_in_write", bus.byte_ready, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", bus.done, 1);
    endtask

    task automatic fetch(input logic [3:0] a, input logic [15:0] e);
        logic [15:0] want;
        bus.fetch_addr = a;
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        check($sformatf("fetch[%0d]", a), bus.fetch_instr, want);
    endtask

    task automatic fetch_model(input logic [3:0] a);
        fetch(a, mv[a] ? mm[a] : 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs[4];
        logic [7:0] b[$];
        vecs = '{'{4'd0, 16'h1234}, '{4'd1, 16'hABCD}, '{4'd2, 16'h0000}, '{4'd15, 16'h0000}};
        bus.start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        bus.byte_last = 1'b0;
        bus.fetch_addr = 4'd0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_ready", bus.byte_ready, 0);
        check("rst_instr", bus.fetch_instr, 0);
        check("rst_loading", bus.loading, 0);
        check("rst_done", bus.done, 0);
        check("rst_hold", bus.cpu_hold, 1);
        check("rst_count", bus.word_count, 0);
        check("rst_err", bus.err, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", bus.byte_ready, 0);
        // two-word load with exact DONE / cpu_hold timing
        start_load();
        b = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        stream(b, 3, 0);
        check("t1_done_in_write", bus.done, 0);
        @(negedge clk);
        check("t1_done", bus.done, 1);
        check("t1_hold_still_high", bus.cpu_hold, 1);
        check("t1_count", bus.word_count, 2);
        check("t1_err", bus.err, 0);
        check("t1_loading", bus.loading, 0);
        check("t1_ready", bus.byte_ready, 0);
        @(negedge clk);
        check("t1_hold_dropped", bus.cpu_hold, 0);
        foreach (vecs[k]) fetch(vecs[k].addr, vecs[k].exp);
        // 34 bytes, no last: the 16th word ends the load
        start_load();
        b.delete();
        for (int k = 0; k < 34; k++) b.push_back(8'(k * 13 + 5));
        stream(b, -1, 0);
        check("t2_accepted", accepted, 32);
        check("t2_done", bus.done, 1);
        check("t2_ready", bus.byte_ready, 0);
        check("t2_count", bus.word_count, 16);
        check("t2_err", bus.err, 0);
        fetch(4'd15, {b[30], b[31]});
        fetch(4'd0, {b[0], b[1]});
        fetch_model(4'd7);
        // reload with an odd byte count; old entries must read as NOP
        start_load();
        fetch(4'd15, 16'h0000);
        b = '{8'h7E, 8'h55, 8'h99};
        stream(b, 2, 0);
        wait_done();
        check("t3_count", bus.word_count, 2);
        check("t3_err", bus.err, 1);
        fetch(4'd1, 16'h9900);
        fetch(4'd0, 16'h7E55);
        fetch(4'd5, 16'h0000);
        fetch(4'd15, 16'h0000);
        // gapped byte_valid
        start_load();
        b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        stream(b, 7, 1);
        wait_done();
        check("t4_count", bus.word_count, mcount);
        check("t4_err", bus.err, 0);
        fetch(4'd2, 16'h89AB);
        for (int k = 0; k < 5; k++) fetch_model(4'(k));
        // reset in the middle of a load
        start_load();
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        stream(b, -1, 0);
        @(negedge clk);
        check("t5_ready_before_reset", bus.byte_ready, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_ready_async", bus.byte_ready, 0);
        check("t5_loading", bus.loading, 0);
        check("t5_hold", bus.cpu_hold, 1);
        check("t5_count", bus.word_count, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_load();
        b = '{8'hBE, 8'hEF};
        stream(b, 1, 0);
        wait_done();
        check("t5_err", bus.err, 0);
        check("t5_words", bus.word_count, 1);
        fetch(4'd0, 16'hBEEF);
        for (int k = 1; k < 4; k++) fetch(4'(k), 16'h0000);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
